// File: rtl/bit_diff_arbiter.sv
// Round-robin arbiter that shares one bit_diff engine among NUM_REQ requesters.
// It issues one job at a time, waits for the engine (with a timeout) and returns a tagged result.
module bit_diff_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255,
  localparam int unsigned RW = $clog2(2 * DATA_WIDTH + 1),
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                eng_go,
  output logic [DATA_WIDTH-1:0]               eng_data,
  input  logic                                eng_done,
  input  logic signed [RW-1:0]                eng_result,
  output logic                                rsp_valid,
  output logic [IW-1:0]                       rsp_id,
  output logic signed [RW-1:0]                rsp_result,
  input  logic                                rsp_ready,
  output logic                                busy,
  output logic                                timeout_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          rr_q, rr_d;
  logic [IW-1:0]          id_q, id_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
  logic                   eng_go_q, eng_go_d;
  logic [DATA_WIDTH-1:0]  eng_data_q, eng_data_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]          rsp_id_q, rsp_id_d;
  logic signed [RW-1:0]   rsp_result_q, rsp_result_d;
  logic                   busy_q, busy_d;
  logic                   timeout_err_q, timeout_err_d;

  logic [IW-1:0]          gnt_idx;
  logic [IW-1:0]          idx;

  // Search from the highest offset down so the nearest valid index at/after rr_q wins.
  always_comb begin
    gnt_idx = '0;
    idx     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IW'((int'(rr_q) + i) % NUM_REQ);
      if (req_valid[idx]) begin
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    req_ready_d   = '0;
    eng_go_d      = 1'b0;
    eng_data_d    = eng_data_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_result_d  = rsp_result_q;
    busy_d        = busy_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          state_d              = StIssue;
          id_d                 = gnt_idx;
          eng_data_d           = req_data[gnt_idx];
          eng_go_d             = 1'b1;
          req_ready_d[gnt_idx] = 1'b1;
          busy_d               = 1'b1;
        end
      end
      StIssue: begin
        // eng_done may still reflect the previous job here, so it is not looked at.
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (eng_done) begin
          state_d      = StResp;
          rsp_result_d = eng_result;
          rsp_valid_d  = 1'b1;
          rsp_id_d     = id_q;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d       = StResp;
          timeout_err_d = 1'b1;
          rsp_result_d  = '0;
          rsp_valid_d   = 1'b1;
          rsp_id_d      = id_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          rr_d        = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      rr_q          <= '0;
      id_q          <= '0;
      cnt_q         <= '0;
      req_ready_q   <= '0;
      eng_go_q      <= 1'b0;
      eng_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_result_q  <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      id_q          <= id_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      eng_go_q      <= eng_go_d;
      eng_data_q    <= eng_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_result_q  <= rsp_result_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign eng_go      = eng_go_q;
  assign eng_data    = eng_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = rsp_result_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule
